// File: rtl/time_set_ctrl_if.sv
// ----------------------------------------------------------------------------
// time_set_ctrl_if
//   Bundles the board-side buttons, the running time from the hh:mm:ss
//   timer and the edited-time / control outputs of time_set_ctrl.
//
//   master : the board/timer side (drives buttons and cur_*, reads results)
//   slave  : time_set_ctrl itself
//
//   set_mod, left, right, up, down : raw asynchronous buttons/switch
//   cur_hours/minutes/seconds      : running time (0-23 / 0-59 / 0-59)
//   set_hours/minutes/seconds      : edited time, valid when load is high
//   load                           : one-cycle strobe, timer loads set_*
//   editing                        : high while the set mode is active
//   pos                            : cursor position 0-5 (digit highlight)
// ----------------------------------------------------------------------------
interface time_set_ctrl_if;
    logic       set_mod;
    logic       left;
    logic       right;
    logic       up;
    logic       down;
    logic [5:0] cur_hours;
    logic [5:0] cur_minutes;
    logic [5:0] cur_seconds;
    logic [5:0] set_hours;
    logic [5:0] set_minutes;
    logic [5:0] set_seconds;
    logic       load;
    logic       editing;
    logic [2:0] pos;

    modport master (
        output set_mod, left, right, up, down,
        output cur_hours, cur_minutes, cur_seconds,
        input  set_hours, set_minutes, set_seconds,
        input  load, editing, pos
    );

    modport slave (
        input  set_mod, left, right, up, down,
        input  cur_hours, cur_minutes, cur_seconds,
        output set_hours, set_minutes, set_seconds,
        output load, editing, pos
    );
endinterface

// File: rtl/time_set_ctrl.sv
// ----------------------------------------------------------------------------
// time_set_ctrl
//   Time-setting sequencer for the digital clock. Debounces the set-mode
//   switch and the four cursor/edit buttons, snapshots the running time on
//   set-mode entry, lets the user move a 6-digit cursor and step the selected
//   digit with modular wrap, and issues a one-cycle load strobe to the timer
//   on set-mode exit.
//
//   Ports:
//     clk    : system clock
//     reset  : synchronous, active-low reset
//     bus    : time_set_ctrl_if.slave (buttons, cur_*, set_*, load,
//              editing, pos)
//
//   Parameters:
//     DEB_CYCLES    : stable cycles before a button level is accepted (>= 2)
//     REPEAT_DELAY  : hold cycles before up/down auto-repeat starts
//     REPEAT_PERIOD : cycles between auto-repeat steps
//
//   Build option:
//     TIME_SET_AUTO_REPEAT_EN : when defined, a held up/down button in EDIT
//     generates extra steps after REPEAT_DELAY and then every REPEAT_PERIOD
//     cycles. When undefined each press gives exactly one step.
//
//   Cursor positions: 0 sec units, 1 sec tens, 2 min units, 3 min tens,
//   4 hr units, 5 hr tens. Raw edge to FSM reaction is DEB_CYCLES+3 cycles.
// ----------------------------------------------------------------------------
module time_set_ctrl #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic           clk,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);

    localparam int unsigned NB  = 5;
    localparam int unsigned DCW = $clog2(DEB_CYCLES);

    // Button bit positions inside the packed button vectors
    localparam int unsigned B_MODE  = 0;
    localparam int unsigned B_LEFT  = 1;
    localparam int unsigned B_RIGHT = 2;
    localparam int unsigned B_UP    = 3;
    localparam int unsigned B_DOWN  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_EDIT,
        S_COMMIT
    } state_e;

    if (DEB_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_cfg_chk
        $error("time_set_ctrl: DEB_CYCLES must be >= 2 and REPEAT_* must be non-zero");
    end

    // ------------------------------------------------------------------
    // Input path: 2-flop synchronizer, debounce counter, rising-edge event
    // ------------------------------------------------------------------
    logic [NB-1:0]          raw;
    logic [NB-1:0]          sync1_q;
    logic [NB-1:0]          sync2_q;
    logic [NB-1:0]          deb_q, deb_d;
    logic [NB-1:0]          deb_prev_q;
    logic [NB-1:0][DCW-1:0] cnt_q, cnt_d;
    logic [NB-1:0]          evt;

    assign raw = {bus.down, bus.up, bus.right, bus.left, bus.set_mod};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // The counter runs only while the synchronized level disagrees with the
    // accepted level; any agreement (bounce back) restarts it from zero.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DCW'(1);
                end
            end
        end
    end

    assign evt = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   editing_w;
    logic   load_w;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (evt[B_MODE]) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_EDIT;
            S_EDIT:    if (!deb_q[B_MODE]) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        editing_w = 1'b0;
        load_w    = 1'b0;
        case (state_q)
            S_CAPTURE, S_EDIT: editing_w = 1'b1;
            S_COMMIT:          load_w    = 1'b1;
            default:           ;
        endcase
    end

    // ------------------------------------------------------------------
    // Auto-repeat: index 0 = up, 1 = down
    // ------------------------------------------------------------------
    logic [1:0] rpt_fire;

`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RCW  = $clog2(RMAX + 1);

    logic [1:0][RCW-1:0] hcnt_q, hcnt_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          held_only;
    logic [1:0]          press;

    assign held_only = {deb_q[B_DOWN] & ~deb_q[B_UP], deb_q[B_UP] & ~deb_q[B_DOWN]};
    assign press     = {evt[B_DOWN], evt[B_UP]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt_q  <= '0;
            phase_q <= '0;
        end else begin
            hcnt_q  <= hcnt_d;
            phase_q <= phase_d;
        end
    end

    // hcnt holds the number of cycles since the press event (0 in the event
    // cycle itself); a non-zero count means the hold was armed by a press
    // in EDIT, so a button already held on EDIT entry never repeats. After
    // each step the count restarts at 1 and phase selects delay vs period.
    always_comb begin
        hcnt_d   = '0;
        phase_d  = '0;
        rpt_fire = '0;
        for (int unsigned j = 0; j < 2; j++) begin
            if (state_q == S_EDIT && held_only[j] && (press[j] || hcnt_q[j] != '0)) begin
                if ((!phase_q[j] && hcnt_q[j] == RCW'(REPEAT_DELAY)) ||
                    ( phase_q[j] && hcnt_q[j] == RCW'(REPEAT_PERIOD))) begin
                    rpt_fire[j] = 1'b1;
                    hcnt_d[j]   = RCW'(1);
                    phase_d[j]  = 1'b1;
                end else begin
                    hcnt_d[j]   = hcnt_q[j] + RCW'(1);
                    phase_d[j]  = phase_q[j];
                end
            end
        end
    end
`else
    assign rpt_fire = '0;
`endif

    // ------------------------------------------------------------------
    // Datapath: snapshot, cursor and digit editing
    // ------------------------------------------------------------------
    logic [5:0] set_h_q, set_h_d;
    logic [5:0] set_m_q, set_m_d;
    logic [5:0] set_s_q, set_s_d;
    logic [2:0] pos_q, pos_d;

    logic       step_up;
    logic       step_dn;
    logic       cur_l;
    logic       cur_r;
    logic [6:0] field7;
    logic [6:0] mod7;
    logic [6:0] step7;
    logic [6:0] sum7;

    assign step_up = evt[B_UP] | rpt_fire[0];
    assign step_dn = evt[B_DOWN] | rpt_fire[1];
    assign cur_l   = evt[B_LEFT] & ~evt[B_RIGHT];
    assign cur_r   = evt[B_RIGHT] & ~evt[B_LEFT];

    always_ff @(posedge clk) begin
        if (!reset) begin
            set_h_q <= '0;
            set_m_q <= '0;
            set_s_q <= '0;
            pos_q   <= '0;
        end else begin
            set_h_q <= set_h_d;
            set_m_q <= set_m_d;
            set_s_q <= set_s_d;
            pos_q   <= pos_d;
        end
    end

    // The field is always taken from the current pos, so an edit that
    // coincides with a cursor move lands on the old digit.
    always_comb begin
        set_h_d = set_h_q;
        set_m_d = set_m_q;
        set_s_d = set_s_q;
        pos_d   = pos_q;

        mod7  = pos_q[2] ? 7'd24 : 7'd60;
        step7 = pos_q[0] ? 7'd10 : 7'd1;
        case (pos_q[2:1])
            2'd0:    field7 = {1'b0, set_s_q};
            2'd1:    field7 = {1'b0, set_m_q};
            default: field7 = {1'b0, set_h_q};
        endcase

        // Operands are below the modulus, so one conditional subtract wraps
        if (step_up) begin
            sum7 = field7 + step7;
        end else begin
            sum7 = field7 + mod7 - step7;
        end
        if (sum7 >= mod7) begin
            sum7 = sum7 - mod7;
        end

        if (state_q == S_CAPTURE) begin
            set_h_d = bus.cur_hours;
            set_m_d = bus.cur_minutes;
            set_s_d = bus.cur_seconds;
            pos_d   = '0;
        end else if (state_q == S_EDIT && deb_q[B_MODE]) begin
            if (step_up ^ step_dn) begin
                case (pos_q[2:1])
                    2'd0:    set_s_d = sum7[5:0];
                    2'd1:    set_m_d = sum7[5:0];
                    default: set_h_d = sum7[5:0];
                endcase
            end
            if (cur_l) begin
                pos_d = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
            end else if (cur_r) begin
                pos_d = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
            end
        end
    end

    assign bus.set_hours   = set_h_q;
    assign bus.set_minutes = set_m_q;
    assign bus.set_seconds = set_s_q;
    assign bus.pos         = pos_q;
    assign bus.editing     = editing_w;
    assign bus.load        = load_w;

endmodule

// File: tb/tb_time_set_ctrl.sv
`timescale 1ns/1ps
module tb_time_set_ctrl;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 5;
`ifdef TIME_SET_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // load monitor, sampled away from the active edge
    int         load_cnt = 0;
    int         load_run = 0;
    int         load_maxrun = 0;
    logic [5:0] ld_h, ld_m, ld_s;

    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            load_cnt++;
            load_run++;
            if (load_run > load_maxrun) load_maxrun = load_run;
            ld_h = bus.set_hours;
            ld_m = bus.set_minutes;
            ld_s = bus.set_seconds;
        end else begin
            load_run = 0;
        end
    end

    // Reference model: fields [0]=sec [1]=min [2]=hr, cursor 0..5
    int m_f[3];
    int m_pos;
    bit m_edit;
    int m_mod[3] = '{60, 60, 24};

    // mask bits: 0 left, 1 right, 2 up, 3 down
    function automatic void model_apply(input logic [3:0] mask);
        int fi, st, v;
        if (!m_edit) return;
        if (mask[2] ^ mask[3]) begin
            fi = m_pos / 2;
            st = (m_pos % 2) ? 10 : 1;
            v  = mask[2] ? m_f[fi] + st : m_f[fi] - st;
            m_f[fi] = ((v % m_mod[fi]) + m_mod[fi]) % m_mod[fi];
        end
        if (mask[0] ^ mask[1]) begin
            m_pos = mask[0] ? (m_pos + 1) % 6 : (m_pos + 5) % 6;
        end
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".pos"}, bus.pos, m_pos);
        chk({tag, ".sec"}, bus.set_seconds, m_f[0]);
        chk({tag, ".min"}, bus.set_minutes, m_f[1]);
        chk({tag, ".hr"},  bus.set_hours,   m_f[2]);
        chk({tag, ".editing"}, bus.editing, int'(m_edit));
    endtask

    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        {bus.down, bus.up, bus.right, bus.left} = mask;
        repeat (hold) @(negedge clk);
        {bus.down, bus.up, bus.right, bus.left} = 4'b0000;
        repeat (DEB + 8) @(negedge clk);
        model_apply(mask);
    endtask

    task automatic enter_session(input int h, input int m, input int s);
        int n;
        @(negedge clk);
        bus.cur_hours   = 6'(h);
        bus.cur_minutes = 6'(m);
        bus.cur_seconds = 6'(s);
        bus.set_mod     = 1'b1;
        n = 0;
        while (n <= 50) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.editing === 1'b1) break;
        end
        chk("enter_latency", n, DEB + 3);
        @(posedge clk);
        #1;
        m_f[0] = s; m_f[1] = m; m_f[2] = h; m_pos = 0; m_edit = 1'b1;
        check_model("capture");
        // running time keeps moving; the snapshot must not follow it
        @(negedge clk);
        bus.cur_hours   = 6'($urandom_range(0, 23));
        bus.cur_minutes = 6'($urandom_range(0, 59));
        bus.cur_seconds = 6'($urandom_range(0, 59));
    endtask

    task automatic exit_session(input bit bounce);
        int base;
        base = load_cnt;
        @(negedge clk);
        if (bounce) begin
            for (int i = 0; i < 6; i++) begin
                bus.set_mod = (i % 2 == 0) ? 1'b0 : 1'b1;
                repeat (2) @(negedge clk);
            end
            chk("bounce_no_load", load_cnt, base);
            chk("bounce_still_editing", bus.editing, 1);
        end
        bus.set_mod = 1'b0;
        repeat (DEB + 20) @(negedge clk);
        m_edit = 1'b0;
        chk("load_count", load_cnt, base + 1);
        chk("load_width", load_maxrun, 1);
        chk("load_hr",  ld_h, m_f[2]);
        chk("load_min", ld_m, m_f[1]);
        chk("load_sec", ld_s, m_f[0]);
        check_model("after_commit");
    endtask

    int trace[34];

    initial begin
        bus.set_mod = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.up = 1'b0; bus.down = 1'b0;
        bus.cur_hours = '0; bus.cur_minutes = '0; bus.cur_seconds = '0;
        m_f = '{0, 0, 0}; m_pos = 0; m_edit = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_model("reset");
        chk("reset.load", bus.load, 0);
        @(negedge clk);
        reset = 1'b1;

        // presses in IDLE are ignored
        for (int i = 0; i < 3; i++) begin
            press(4'($urandom_range(1, 15)), DEB + 2);
            check_model("idle_press");
        end

        // directed session at 12:34:56
        enter_session(12, 34, 56);
        for (int i = 0; i < 5; i++) begin
            press(4'b0010, DEB + 1);
            chk("right_pos", bus.pos, (5 - i));
        end
        press(4'b0100, DEB + 1);
        chk("up_sec_tens", bus.set_seconds, 6);
        chk("up_min_same", bus.set_minutes, 34);
        for (int i = 0; i < 5; i++) begin
            press(4'b0001, DEB + 1);
            check_model("left");
        end
        chk("left_wrap_pos", bus.pos, 0);
        press(4'b0010, DEB + 1);
        press(4'b0100, DEB + 1);
        chk("hr_tens_up1", bus.set_hours, 22);
        press(4'b0100, DEB + 1);
        chk("hr_tens_up2", bus.set_hours, 8);
        press(4'b1100, DEB + 3);
        check_model("up_down_same");
        press(4'b0011, DEB + 3);
        check_model("left_right_same");
        exit_session(1'b1);

        // randomized sessions
        for (int s = 0; s < 6; s++) begin
            enter_session($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            for (int p = 0; p < 12; p++) begin
                press(4'($urandom_range(1, 15)), $urandom_range(DEB + 1, DEB + 6));
                check_model("rand_press");
            end
            exit_session(s % 2 == 1);
        end

        // reset in the middle of an edit
        enter_session(5, 6, 7);
        press(4'b0100, DEB + 2);
        check_model("pre_reset");
        begin
            int base, ed_max;
            base = load_cnt;
            @(negedge clk);
            reset = 1'b0;
            bus.set_mod = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            m_f = '{0, 0, 0}; m_pos = 0; m_edit = 1'b0;
            check_model("mid_reset");
            @(negedge clk);
            reset = 1'b1;
            ed_max = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus.editing === 1'b1) ed_max = 1;
            end
            chk("reset_editing_low", ed_max, 0);
            chk("reset_no_load", load_cnt, base);
        end

        // auto-repeat hold of up at sec 58
        enter_session(1, 2, 58);
        @(negedge clk);
        bus.up = 1'b1;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            trace[c] = bus.set_seconds;
        end
        @(negedge clk);
        bus.up = 1'b0;
        repeat (DEB + 12) @(negedge clk);
        chk("hold_before_event", trace[6], 58);
        chk("hold_press_step", trace[7], 59);
        chk("hold_before_rpt", trace[26], 59);
        chk("hold_rpt1", trace[27], AR ? 0 : 59);
        chk("hold_rpt2", trace[32], AR ? 1 : 59);
        m_f[0] = AR ? 2 : 59;
        check_model("hold_final");
        exit_session(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
